pueo_uram_read_sched: RTL and testbench

PUEO_URAM_READ_SCHED -- requirements
Module: pueo_uram_read_sched

---
 rtl/pueo_uram_read_sched_if.sv | 33 +++
 rtl/pueo_uram_read_sched.sv | 146 ++++++++++++++
 tb/tb_pueo_uram_read_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pueo_uram_read_sched_if.sv
// Readout scheduler bus: requester handshake, buffer address/data strobes
// and completion status, bundled for the scheduler and its environment.
interface pueo_uram_read_sched_if #(
   parameter int NREQ     = 4,
   parameter int ADDRLEN  = 14,
   parameter int ADDRBITS = 16
);
   logic [NREQ-1:0]         req_valid_i;
   logic [NREQ*ADDRLEN-1:0] req_addr_i;
   logic [NREQ-1:0]         req_ready_o;
   logic [ADDRBITS-1:0]     uram_addr_o;
   logic                    uram_valid_o;
   logic                    uram_ready_i;
   logic                    uram_dvalid_i;
   logic                    done_o;
   logic [$clog2(NREQ)-1:0] done_id_o;
   logic                    timeout_o;
   logic                    busy_o;

   // Scheduler side
   modport master (
      input  req_valid_i, req_addr_i, uram_ready_i, uram_dvalid_i,
      output req_ready_o, uram_addr_o, uram_valid_o, done_o, done_id_o,
             timeout_o, busy_o
   );

   // Requesters and buffer side
   modport slave (
      output req_valid_i, req_addr_i, uram_ready_i, uram_dvalid_i,
      input  req_ready_o, uram_addr_o, uram_valid_o, done_o, done_id_o,
             timeout_o, busy_o
   );
endinterface

// File: rtl/pueo_uram_read_sched.sv
// URAM readout scheduler: round-robin arbitration between requesters, issue
// of a pre-trigger-adjusted base address, beat counting with a watchdog.
// One readout is outstanding at a time.
module pueo_uram_read_sched #(
   parameter int NREQ     = 4,
   parameter int ADDRLEN  = 14,
   parameter int ADDRBITS = 16,
   parameter int RDLEN    = 1024,
   parameter int PRETRIG  = 256,
   parameter int TIMEOUT  = 8192
)(
   input logic                    memclk,
   input logic                    memclk_rstn_i,
   pueo_uram_read_sched_if.master sched_bus
);
   localparam int IDW  = $clog2(NREQ);
   localparam int CNTW = $clog2(RDLEN) + 1;
   localparam int WDW  = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_ISSUE = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [1:0]          r_rst_sync;
   logic                w_rstn;
   logic [IDW-1:0]      r_ptr;
   logic [IDW-1:0]      w_sel;
   logic                w_found;
   logic [ADDRLEN-1:0]  w_req_addr;
   logic [ADDRLEN-1:0]  w_issue_addr;
   logic [NREQ-1:0]     r_req_ready;
   logic [IDW-1:0]      r_done_id;
   logic [ADDRBITS-1:0] r_uram_addr;
   logic                r_uram_valid;
   logic [CNTW-1:0]     r_beat_cnt;
   logic [WDW-1:0]      r_wdog;
   logic                w_active;
   logic                w_wdog_exp;

   // Reset asserts at once but releases only after two memclk edges
   always_ff @(posedge memclk or negedge memclk_rstn_i) begin
      if (!memclk_rstn_i) r_rst_sync <= '0;
      else                r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rstn = r_rst_sync[1];

   // Round-robin search starting at the pointer, wrapping past NREQ-1
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && sched_bus.req_valid_i[(int'(r_ptr) + i) % NREQ]) begin
            w_found = 1'b1;
            w_sel   = IDW'((int'(r_ptr) + i) % NREQ);
         end
      end
   end

   // Pre-trigger offset applied modulo the URAM depth so low addresses wrap
   assign w_req_addr   = sched_bus.req_addr_i[int'(w_sel)*ADDRLEN +: ADDRLEN];
   assign w_issue_addr = ADDRLEN'(w_req_addr - ADDRLEN'(PRETRIG));

   assign w_active   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign w_wdog_exp = w_active && (r_wdog == WDW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge memclk or negedge w_rstn) begin
      if (!w_rstn) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic; the watchdog wins over a same-cycle final beat
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (|sched_bus.req_valid_i) w_state_next = S_GRANT;
         S_GRANT: w_state_next = S_ISSUE;
         S_ISSUE: begin
            if (w_wdog_exp)                  w_state_next = S_IDLE;
            else if (sched_bus.uram_ready_i) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_wdog_exp)
               w_state_next = S_IDLE;
            else if (sched_bus.uram_dvalid_i && r_beat_cnt == CNTW'(RDLEN - 1))
               w_state_next = S_DONE;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Grant capture on entry to GRANT: one-hot ready pulse, id, address, pointer
   always_ff @(posedge memclk or negedge w_rstn) begin
      if (!w_rstn) begin
         r_req_ready <= '0;
         r_done_id   <= '0;
         r_uram_addr <= '0;
         r_ptr       <= '0;
      end else if (r_state == S_IDLE && w_found) begin
         r_req_ready <= NREQ'(1) << w_sel;
         r_done_id   <= w_sel;
         r_uram_addr <= ADDRBITS'(w_issue_addr);
         r_ptr       <= IDW'((int'(w_sel) + 1) % NREQ);
      end else begin
         r_req_ready <= '0;
      end
   end

   // Address valid is high exactly while the FSM sits in ISSUE
   always_ff @(posedge memclk or negedge w_rstn) begin
      if (!w_rstn) r_uram_valid <= 1'b0;
      else         r_uram_valid <= (w_state_next == S_ISSUE);
   end

   // Beat counter: counts only in DRAIN, cleared everywhere else and on abort
   always_ff @(posedge memclk or negedge w_rstn) begin
      if (!w_rstn)
         r_beat_cnt <= '0;
      else if (r_state == S_DRAIN && !w_wdog_exp) begin
         if (sched_bus.uram_dvalid_i) r_beat_cnt <= r_beat_cnt + 1'b1;
      end else
         r_beat_cnt <= '0;
   end

   // Watchdog: counts ISSUE+DRAIN cycles, zero otherwise
   always_ff @(posedge memclk or negedge w_rstn) begin
      if (!w_rstn)                  r_wdog <= '0;
      else if (w_active && !w_wdog_exp) r_wdog <= r_wdog + 1'b1;
      else                          r_wdog <= '0;
   end

   assign sched_bus.req_ready_o  = r_req_ready;
   assign sched_bus.uram_addr_o  = r_uram_addr;
   assign sched_bus.uram_valid_o = r_uram_valid;
   assign sched_bus.done_o       = (r_state == S_DONE);
   assign sched_bus.done_id_o    = r_done_id;
   assign sched_bus.timeout_o    = w_wdog_exp;
   assign sched_bus.busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_pueo_uram_read_sched.sv
// Directed bench for pueo_uram_read_sched with default parameters.
module tb_pueo_uram_read_sched;
   localparam int NREQ    = 4;
   localparam int ADDRLEN = 14;
   localparam int RDLEN   = 1024;
   localparam int TIMEOUT = 8192;

   logic memclk;
   logic memclk_rstn_i;
   int   compared;
   int   mismatched;

   pueo_uram_read_sched_if #(.NREQ(NREQ), .ADDRLEN(ADDRLEN), .ADDRBITS(16)) bus_if ();

   pueo_uram_read_sched dut (
      .memclk        (memclk),
      .memclk_rstn_i (memclk_rstn_i),
      .sched_bus     (bus_if)
   );

   initial memclk = 1'b0;
   always #5 memclk = ~memclk;

   task automatic tick();
      @(posedge memclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete readout starting from an IDLE cycle with the request present.
   // A beat is also driven during the ISSUE cycle; it must not be counted.
   task automatic readout(input int exp_id, input logic [31:0] exp_addr,
                          input int bp, input bit drop);
      tick();
      check("grant_ready", 32'(bus_if.req_ready_o), 32'(1) << exp_id);
      check("grant_id", 32'(bus_if.done_id_o), 32'(exp_id));
      check("grant_busy", 32'(bus_if.busy_o), 32'd1);
      if (drop) bus_if.req_valid_i = '0;
      tick();
      check("issue_valid", 32'(bus_if.uram_valid_o), 32'd1);
      check("issue_addr", 32'(bus_if.uram_addr_o), exp_addr);
      check("ready_one_cycle", 32'(bus_if.req_ready_o), 32'd0);
      for (int i = 0; i < bp; i++) begin
         tick();
         check("bp_valid", 32'(bus_if.uram_valid_o), 32'd1);
         check("bp_addr", 32'(bus_if.uram_addr_o), exp_addr);
      end
      bus_if.uram_ready_i  = 1'b1;
      bus_if.uram_dvalid_i = 1'b1;
      tick();
      bus_if.uram_ready_i = 1'b0;
      check("valid_drop", 32'(bus_if.uram_valid_o), 32'd0);
      repeat (RDLEN - 1) tick();
      check("no_early_done", 32'(bus_if.done_o), 32'd0);
      tick();
      bus_if.uram_dvalid_i = 1'b0;
      check("done", 32'(bus_if.done_o), 32'd1);
      check("done_id", 32'(bus_if.done_id_o), 32'(exp_id));
      check("no_timeout", 32'(bus_if.timeout_o), 32'd0);
      tick();
      check("done_len", 32'(bus_if.done_o), 32'd0);
      check("back_idle", 32'(bus_if.busy_o), 32'd0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      memclk_rstn_i        = 1'b0;
      bus_if.req_valid_i   = '0;
      bus_if.req_addr_i    = '0;
      bus_if.uram_ready_i  = 1'b0;
      bus_if.uram_dvalid_i = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(bus_if.busy_o), 32'd0);
      check("rst_valid", 32'(bus_if.uram_valid_o), 32'd0);
      check("rst_addr", 32'(bus_if.uram_addr_o), 32'd0);
      check("rst_done", 32'(bus_if.done_o), 32'd0);
      check("rst_timeout", 32'(bus_if.timeout_o), 32'd0);
      check("rst_ready", 32'(bus_if.req_ready_o), 32'd0);
      check("rst_id", 32'(bus_if.done_id_o), 32'd0);

      // Fairness: all four held; order 0,1,2,3,0 from reset
      bus_if.req_addr_i[0*ADDRLEN +: ADDRLEN] = 14'h0400;
      bus_if.req_addr_i[1*ADDRLEN +: ADDRLEN] = 14'h1000;
      bus_if.req_addr_i[2*ADDRLEN +: ADDRLEN] = 14'h2000;
      bus_if.req_addr_i[3*ADDRLEN +: ADDRLEN] = 14'h3000;
      bus_if.req_valid_i = 4'b1111;
      memclk_rstn_i = 1'b1;
      tick();
      check("sync_release_edge1", 32'(bus_if.busy_o), 32'd0);
      tick();
      readout(0, 32'h0300, 0, 1'b0);
      readout(1, 32'h0F00, 0, 1'b0);
      readout(2, 32'h1F00, 0, 1'b0);
      readout(3, 32'h2F00, 0, 1'b0);
      readout(0, 32'h0300, 0, 1'b0);
      bus_if.req_valid_i = '0;

      // Single request from requester 0, dropped during GRANT
      bus_if.req_valid_i = 4'b0001;
      readout(0, 32'h0300, 0, 1'b1);

      // Address below the pre-trigger offset wraps
      bus_if.req_addr_i[1*ADDRLEN +: ADDRLEN] = 14'h0010;
      bus_if.req_valid_i = 4'b0010;
      readout(1, 32'h3F10, 0, 1'b1);

      // Backpressure: ready withheld for 50 cycles
      bus_if.req_addr_i[2*ADDRLEN +: ADDRLEN] = 14'h2345;
      bus_if.req_valid_i = 4'b0100;
      readout(2, 32'h2245, 50, 1'b1);

      // Timeout: accepted address, only 10 beats; cycle 1 of ISSUE+DRAIN is ISSUE
      bus_if.req_addr_i[3*ADDRLEN +: ADDRLEN] = 14'h0180;
      bus_if.req_valid_i = 4'b1000;
      tick();
      check("to_grant", 32'(bus_if.req_ready_o), 32'b1000);
      bus_if.req_valid_i = '0;
      tick();
      check("to_issue_addr", 32'(bus_if.uram_addr_o), 32'h0080);
      bus_if.uram_ready_i = 1'b1;
      tick();
      bus_if.uram_ready_i  = 1'b0;
      bus_if.uram_dvalid_i = 1'b1;
      repeat (10) tick();
      bus_if.uram_dvalid_i = 1'b0;
      repeat (TIMEOUT - 1 - 12) tick();
      check("to_not_yet", 32'(bus_if.timeout_o), 32'd0);
      check("to_busy", 32'(bus_if.busy_o), 32'd1);
      tick();
      check("to_pulse", 32'(bus_if.timeout_o), 32'd1);
      check("to_no_done", 32'(bus_if.done_o), 32'd0);
      bus_if.req_valid_i = 4'b1111;
      tick();
      check("to_len", 32'(bus_if.timeout_o), 32'd0);
      check("to_idle", 32'(bus_if.busy_o), 32'd0);
      check("to_idle_no_done", 32'(bus_if.done_o), 32'd0);
      readout(0, 32'h0300, 0, 1'b1);

      // Reset in the middle of DRAIN at beat 500
      bus_if.req_valid_i = 4'b0010;
      tick();
      check("mid_grant", 32'(bus_if.req_ready_o), 32'b0010);
      bus_if.req_valid_i = '0;
      tick();
      check("mid_addr", 32'(bus_if.uram_addr_o), 32'h3F10);
      bus_if.uram_ready_i = 1'b1;
      tick();
      bus_if.uram_ready_i  = 1'b0;
      bus_if.uram_dvalid_i = 1'b1;
      repeat (500) tick();
      memclk_rstn_i = 1'b0;
      #1;
      check("arst_busy", 32'(bus_if.busy_o), 32'd0);
      check("arst_valid", 32'(bus_if.uram_valid_o), 32'd0);
      check("arst_addr", 32'(bus_if.uram_addr_o), 32'd0);
      check("arst_id", 32'(bus_if.done_id_o), 32'd0);
      check("arst_ready", 32'(bus_if.req_ready_o), 32'd0);
      tick();
      tick();
      check("arst_no_done", 32'(bus_if.done_o), 32'd0);
      check("arst_no_timeout", 32'(bus_if.timeout_o), 32'd0);
      bus_if.uram_dvalid_i = 1'b0;
      bus_if.req_valid_i   = 4'b0100;
      memclk_rstn_i = 1'b1;
      tick();
      check("arst_release_edge1", 32'(bus_if.busy_o), 32'd0);
      tick();
      readout(2, 32'h2245, 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
